// File: rtl/channel_mixer.sv
// Stereo channel mixer: per-channel value and routing/attenuation memories, swept once per
// start pulse into saturated left (A+C) and right (B+D) samples.
module channel_mixer #(
   parameter int unsigned NUM_BANKS             = 2,
   parameter int unsigned NUM_CHANNELS_PER_BANK = 9,
   parameter int unsigned OP_OUT_WIDTH          = 13,
   parameter int unsigned SAMPLE_WIDTH          = 16,
   parameter int unsigned ATTEN_WIDTH           = 3,
   localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int unsigned CW = (NUM_CHANNELS_PER_BANK > 1) ? $clog2(NUM_CHANNELS_PER_BANK) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           sample_clk_en,
   input  logic                           start,
   input  logic                           ch_wr_valid,
   input  logic [BW-1:0]                  ch_wr_bank,
   input  logic [CW-1:0]                  ch_wr_channel,
   input  logic signed [OP_OUT_WIDTH-1:0] ch_wr_data,
   input  logic                           cfg_wr_valid,
   input  logic [BW-1:0]                  cfg_wr_bank,
   input  logic [CW-1:0]                  cfg_wr_channel,
   input  logic [ATTEN_WIDTH+3:0]         cfg_wr_data,
   output logic                           ready,
   output logic                           busy,
   output logic                           sample_valid,
   output logic signed [SAMPLE_WIDTH-1:0] sample_l,
   output logic signed [SAMPLE_WIDTH-1:0] sample_r
);

   localparam int unsigned N   = NUM_BANKS * NUM_CHANNELS_PER_BANK;
   localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CFW = ATTEN_WIDTH + 4;
   localparam int unsigned AW  = OP_OUT_WIDTH + $clog2(N) + 2;
   localparam int unsigned EW  = ((AW > SAMPLE_WIDTH) ? AW : SAMPLE_WIDTH) + 1;

   typedef enum logic [2:0] {StClear, StIdle, StRun, StDrain, StDone} state_e;

   state_e                         state_q;
   logic [IW-1:0]                  idx_q;
   logic                           ready_q, busy_q, done_q, sample_valid_q, rd_vld_q;
   logic signed [AW-1:0]           acc_l_q, acc_r_q, acc_l_d, acc_r_d, term;
   logic signed [OP_OUT_WIDTH-1:0] rd_val_q;
   logic [CFW-1:0]                 rd_cfg_q;
   logic signed [SAMPLE_WIDTH-1:0] sample_l_q, sample_r_q;
   logic                           ch_wr_ok, cfg_wr_ok;

   logic signed [OP_OUT_WIDTH-1:0] val_mem [N];
   logic [CFW-1:0]                 cfg_mem [N];

   function automatic logic in_range(input logic [BW-1:0] b, input logic [CW-1:0] c);
      return (32'(b) < NUM_BANKS) && (32'(c) < NUM_CHANNELS_PER_BANK);
   endfunction

   function automatic logic [IW-1:0] flat_idx(input logic [BW-1:0] b, input logic [CW-1:0] c);
      return IW'(32'(b) * NUM_CHANNELS_PER_BANK + 32'(c));
   endfunction

   function automatic logic signed [SAMPLE_WIDTH-1:0] sat(input logic signed [AW-1:0] a);
      logic signed [EW-1:0] x, hi, lo;
      x  = {{(EW-AW){a[AW-1]}}, a};
      hi = {{(EW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
      lo = {{(EW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
      if (x > hi) begin
         return hi[SAMPLE_WIDTH-1:0];
      end else if (x < lo) begin
         return lo[SAMPLE_WIDTH-1:0];
      end
      return x[SAMPLE_WIDTH-1:0];
   endfunction

   assign ch_wr_ok  = ch_wr_valid && !reset && (state_q != StClear)
                      && in_range(ch_wr_bank, ch_wr_channel);
   assign cfg_wr_ok = cfg_wr_valid && !reset && (state_q != StClear)
                      && in_range(cfg_wr_bank, cfg_wr_channel);

   // Non-blocking writes alongside the registered read give read-first behaviour.
   always_ff @(posedge clk) begin
      if (state_q == StClear) begin
         val_mem[idx_q] <= '0;
         cfg_mem[idx_q] <= {{ATTEN_WIDTH{1'b0}}, 4'b1111};
      end else begin
         if (ch_wr_ok) val_mem[flat_idx(ch_wr_bank, ch_wr_channel)] <= ch_wr_data;
         if (cfg_wr_ok) cfg_mem[flat_idx(cfg_wr_bank, cfg_wr_channel)] <= cfg_wr_data;
      end
      if (state_q == StRun) begin
         rd_val_q <= val_mem[idx_q];
         rd_cfg_q <= cfg_mem[idx_q];
      end
   end

   // cfg bits: {atten, chd, chc, chb, cha}; routing multiplier is the sum of two enables.
   always_comb begin
      term = $signed({{(AW-OP_OUT_WIDTH){rd_val_q[OP_OUT_WIDTH-1]}}, rd_val_q})
             >>> rd_cfg_q[CFW-1:4];
      acc_l_d = acc_l_q;
      acc_r_d = acc_r_q;
      if (rd_vld_q) begin
         if (rd_cfg_q[0]) acc_l_d = acc_l_d + term;
         if (rd_cfg_q[2]) acc_l_d = acc_l_d + term;
         if (rd_cfg_q[1]) acc_r_d = acc_r_d + term;
         if (rd_cfg_q[3]) acc_r_d = acc_r_d + term;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StClear;
         idx_q          <= '0;
         ready_q        <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         sample_valid_q <= 1'b0;
         rd_vld_q       <= 1'b0;
         acc_l_q        <= '0;
         acc_r_q        <= '0;
         sample_l_q     <= '0;
         sample_r_q     <= '0;
      end else begin
         sample_valid_q <= done_q;
         done_q         <= 1'b0;
         rd_vld_q       <= 1'b0;
         if (sample_clk_en && busy_q) begin
            // Abort: drop the partial sweep, keep the last presented sample.
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            acc_l_q <= '0;
            acc_r_q <= '0;
         end else begin
            unique case (state_q)
               StClear: begin
                  if (idx_q == IW'(N - 1)) begin
                     state_q <= StIdle;
                     idx_q   <= '0;
                     ready_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
               StIdle: begin
                  if (start && !sample_clk_en) begin
                     state_q <= StRun;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                     acc_l_q <= '0;
                     acc_r_q <= '0;
                  end
               end
               StRun: begin
                  rd_vld_q <= 1'b1;
                  acc_l_q  <= acc_l_d;
                  acc_r_q  <= acc_r_d;
                  if (idx_q == IW'(N - 1)) begin
                     state_q <= StDrain;
                     idx_q   <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
               StDrain: begin
                  acc_l_q <= acc_l_d;
                  acc_r_q <= acc_r_d;
                  state_q <= StDone;
               end
               StDone: begin
                  sample_l_q <= sat(acc_l_q);
                  sample_r_q <= sat(acc_r_q);
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= StIdle;
               end
               default: begin
                  state_q <= StClear;
                  idx_q   <= '0;
               end
            endcase
         end
      end
   end

   assign ready        = ready_q;
   assign busy         = busy_q;
   assign sample_valid = sample_valid_q;
   assign sample_l     = sample_l_q;
   assign sample_r     = sample_r_q;

endmodule

// File: tb/tb_channel_mixer.sv
// Scoreboard bench for channel_mixer: model mixes its own copy of the channel tables.
module tb_channel_mixer;

   localparam int N = 18;

   logic clk = 1'b0;
   logic reset = 1'b1, sample_clk_en = 1'b0, start = 1'b0;
   logic ch_wr_valid = 1'b0, cfg_wr_valid = 1'b0;
   logic [0:0] ch_wr_bank = '0, cfg_wr_bank = '0;
   logic [3:0] ch_wr_channel = '0, cfg_wr_channel = '0;
   logic signed [12:0] ch_wr_data = '0;
   logic [6:0] cfg_wr_data = '0;
   logic ready, busy, sample_valid;
   logic signed [15:0] sample_l, sample_r;

   always #5 clk = ~clk;

   channel_mixer dut (
      .clk            (clk),
      .reset          (reset),
      .sample_clk_en  (sample_clk_en),
      .start          (start),
      .ch_wr_valid    (ch_wr_valid),
      .ch_wr_bank     (ch_wr_bank),
      .ch_wr_channel  (ch_wr_channel),
      .ch_wr_data     (ch_wr_data),
      .cfg_wr_valid   (cfg_wr_valid),
      .cfg_wr_bank    (cfg_wr_bank),
      .cfg_wr_channel (cfg_wr_channel),
      .cfg_wr_data    (cfg_wr_data),
      .ready          (ready),
      .busy           (busy),
      .sample_valid   (sample_valid),
      .sample_l       (sample_l),
      .sample_r       (sample_r)
   );

   typedef struct {int l; int r; int due;} exp_t;

   int total = 0, bad = 0, edge_cnt = 0;
   exp_t sb[$];
   exp_t mon_e;
   int mdl_val[N];
   logic [6:0] mdl_cfg[N];
   int last_l = 0, last_r = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Monitor: every sample pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (sample_valid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_sample: got pulse l=%0d r=%0d want none", sample_l,
                     sample_r);
         end else begin
            mon_e = sb.pop_front();
            check("sample_l", sample_l, mon_e.l);
            check("sample_r", sample_r, mon_e.r);
            check("latency", edge_cnt, mon_e.due);
         end
      end
   end

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         mdl_val[i] = 0;
         mdl_cfg[i] = 7'b000_1111;
      end
   endfunction

   function automatic void mix(output int l, output int r);
      l = 0;
      r = 0;
      for (int i = 0; i < N; i++) begin
         int t;
         t = mdl_val[i] >>> int'(mdl_cfg[i][6:4]);
         l += t * (int'(mdl_cfg[i][0]) + int'(mdl_cfg[i][2]));
         r += t * (int'(mdl_cfg[i][1]) + int'(mdl_cfg[i][3]));
      end
      if (l > 32767) l = 32767;
      if (l < -32768) l = -32768;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
   endfunction

   task automatic wr_val(input int b, input int c, input int v);
      @(negedge clk);
      ch_wr_valid = 1'b1;
      ch_wr_bank = 1'(b);
      ch_wr_channel = 4'(c);
      ch_wr_data = 13'(v);
      @(negedge clk);
      ch_wr_valid = 1'b0;
      if (b < 2 && c < 9) mdl_val[b*9+c] = v;
   endtask

   task automatic wr_cfg(input int b, input int c, input logic [6:0] v);
      @(negedge clk);
      cfg_wr_valid = 1'b1;
      cfg_wr_bank = 1'(b);
      cfg_wr_channel = 4'(c);
      cfg_wr_data = v;
      @(negedge clk);
      cfg_wr_valid = 1'b0;
      if (b < 2 && c < 9) mdl_cfg[b*9+c] = v;
   endtask

   task automatic sweep();
      int l, r;
      mix(l, r);
      @(negedge clk);
      start = 1'b1;
      sb.push_back('{l, r, edge_cnt + 22});
      last_l = l;
      last_r = r;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_sb(input string name);
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      check(name, sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_l", sample_l, 0);
      check("rst_r", sample_r, 0);
      reset = 1'b0;
      repeat (17) @(negedge clk);
      check("clear_ready_early", ready, 0);
      @(negedge clk);
      check("clear_ready", ready, 1);

      wr_val(0, 0, 1000);
      sweep();
      wait_sb("t_basic");

      wr_cfg(0, 0, {3'd2, 4'b0001});
      wr_val(0, 0, -1001);
      sweep();
      wait_sb("t_atten");

      wr_cfg(0, 0, 7'b000_1111);
      for (int i = 0; i < N; i++) wr_val(i / 9, i % 9, 4095);
      sweep();
      wait_sb("t_sat_pos");
      for (int i = 0; i < N; i++) wr_val(i / 9, i % 9, -4096);
      sweep();
      wait_sb("t_sat_neg");

      for (int i = 0; i < N; i++) wr_val(i / 9, i % 9, 0);
      wr_val(1, 8, 500);
      wr_cfg(1, 8, {3'd0, 4'b1010});
      sweep();
      wait_sb("t_last_idx");

      // Abort mid-sweep: no pulse, outputs held, busy drops.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_before", busy, 1);
      sample_clk_en = 1'b1;
      @(negedge clk);
      sample_clk_en = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_hold_l", sample_l, last_l);
      check("abort_hold_r", sample_r, last_r);
      repeat (30) @(negedge clk);
      check("abort_still_l", sample_l, last_l);
      wr_val(0, 3, -77);
      sweep();
      wait_sb("t_after_abort");

      // Start and sample_clk_en together: no sweep.
      @(negedge clk);
      start = 1'b1;
      sample_clk_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sample_clk_en = 1'b0;
      check("start_vs_en_busy", busy, 0);
      repeat (25) @(negedge clk);

      // Random tables; index 0 rewritten after it was read must not affect this sweep.
      for (int it = 0; it < 6; it++) begin
         int k;
         k = $urandom_range(5, 12);
         for (int j = 0; j < k; j++) begin
            wr_val($urandom_range(0, 1), $urandom_range(0, 10),
                   int'($urandom_range(0, 8191)) - 4096);
            wr_cfg($urandom_range(0, 1), $urandom_range(0, 10),
                   {3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))});
         end
         sweep();
         wr_val(0, 0, int'($urandom_range(0, 8191)) - 4096);
         wait_sb("t_random");
      end

      // Reset mid-RUN, then a write and a start during the clear sweep.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_ready", ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_l", sample_l, 0);
      check("mid_rst_r", sample_r, 0);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      ch_wr_valid = 1'b1;
      ch_wr_bank = 1'b0;
      ch_wr_channel = 4'd0;
      ch_wr_data = 13'sd777;
      start = 1'b1;
      @(negedge clk);
      ch_wr_valid = 1'b0;
      start = 1'b0;
      check("clear_start_busy", busy, 0);
      repeat (15) @(negedge clk);
      check("reclear_ready_early", ready, 0);
      @(negedge clk);
      check("reclear_ready", ready, 1);
      sweep();
      wait_sb("t_after_clear");

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/channel_mixer.md
Name: channel_mixer

Overview:
- Parametrised successor to the fixed OPL3 channel accumulator. Stores per-channel output values and per-channel routing/attenuation config.
- On each start pulse, sweeps all NUM_BANKS*NUM_CHANNELS_PER_BANK channels through a one-cycle-read pipeline and accumulates the enabled A/B/C/D outputs into left (A+C) and right (B+D).
- Saturates the sums to SAMPLE_WIDTH and presents one stereo sample per sweep to dac_prep.
- Adds features the fixed block lacks: arbitrary bank/channel count, per-channel attenuation, a reset clear sweep, and abort/restart.

Parameters:
NUM_BANKS, 2, number of register banks
NUM_CHANNELS_PER_BANK, 9, channels per bank; N = NUM_BANKS*NUM_CHANNELS_PER_BANK
OP_OUT_WIDTH, 13, signed channel value width
SAMPLE_WIDTH, 16, signed output sample width
ATTEN_WIDTH, 3, per-channel right-shift attenuation field width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_clk_en  in  1  sample-period strobe; aborts any sweep in progress
start  in  1  one-cycle pulse; begins a sweep when ready && !busy
ch_wr_valid  in  1  channel value write strobe
ch_wr_bank  in  max(1,$clog2(NUM_BANKS))  bank of value write
ch_wr_channel  in  $clog2(NUM_CHANNELS_PER_BANK)  channel of value write
ch_wr_data  in  OP_OUT_WIDTH signed  channel value
cfg_wr_valid  in  1  config write strobe
cfg_wr_bank  in  max(1,$clog2(NUM_BANKS))  bank of config write
cfg_wr_channel  in  $clog2(NUM_CHANNELS_PER_BANK)  channel of config write
cfg_wr_data  in  ATTEN_WIDTH+4  {atten, chd, chc, chb, cha}
ready  out  1  high once the clear sweep completes
busy  out  1  high while a mix sweep is in progress
sample_valid  out  1  one-cycle pulse; new sample on sample_l/sample_r
sample_l  out  SAMPLE_WIDTH signed  left sample, held until next pulse
sample_r  out  SAMPLE_WIDTH signed  right sample, held until next pulse

Behaviour:
- Memory index = bank*NUM_CHANNELS_PER_BANK + channel.
- Writes with channel >= NUM_CHANNELS_PER_BANK or bank >= NUM_BANKS are ignored.
- Both memories are read-first: a same-cycle write to the address being read returns the old value.
- Reset (any cycle, including mid-sweep) forces:
  - state CLEAR, ready=0, busy=0, sample_valid=0, sample_l=sample_r=0, accumulators=0.
- CLEAR lasts N cycles, one index per cycle:
  - value memory entry <= 0; config entry <= {atten=0, route=4'b1111}.
  - External writes are ignored during CLEAR. start is ignored.
  - CLEAR ends by entering IDLE with ready=1.
- States and transitions:
  - IDLE: on start -> RUN, with rd index=0 and accumulators=0.
  - RUN: issue read of index i each cycle, i=0..N-1; after i=N-1 -> DRAIN.
  - DRAIN: accumulates the final returned entry -> DONE.
  - DONE: clamps and registers sample_l/sample_r -> IDLE. sample_valid is registered and pulses in the following cycle.
- Latency: sample_valid is high exactly N+3 cycles after the edge that samples start (21 for defaults).
- busy=1 in RUN, DRAIN and DONE.
- Per-entry term = value >>> atten (arithmetic shift, floor toward -inf).
  - acc_l += term*(cha+chc); acc_r += term*(chb+chd). Multiplier is 0, 1 or 2.
- Accumulator width = OP_OUT_WIDTH + $clog2(N) + 2; it must never wrap.
- Clamp to [-2**(SAMPLE_WIDTH-1), 2**(SAMPLE_WIDTH-1)-1].
- sample_clk_en high in RUN/DRAIN/DONE:
  - next state IDLE, accumulators=0, no sample_valid; outputs keep their previous value.
  - If sample_clk_en and start are high in the same cycle, sample_clk_en wins and no sweep starts.
  - sample_clk_en has no effect in CLEAR.
- start while busy, or while ready=0, is ignored (no queueing).
- Writes during RUN are accepted; an entry read before its write uses the old value.

Test Plan:
- Reset, wait 18 cycles (ready=1); write ch_wr bank0 ch0 = 1000; pulse start -> sample_valid 21 cycles later; sample_l=sample_r=2000.
- cfg bank0 ch0 = {atten=2, route=4'b0001}; value -1001; start -> sample_l=-251, sample_r=0.
- All 18 channels = 4095 with default config -> sample_l=sample_r=32767; all = -4096 -> both -32768.
- Bank1 ch8 = 500 with route 4'b1010 (chb, chd) -> sample_l=0, sample_r=1000; confirms index 17 is mixed.
- sample_clk_en at cycle 10 of a sweep -> no sample_valid, outputs unchanged, busy=0 next cycle; a new start then produces a correct result.
- Reset asserted mid-RUN -> outputs 0, ready=0 for 18 cycles; all values read back as 0 (a sweep gives 0/0); start during CLEAR is ignored.
